// File: rtl/alu_vector_checker.sv
// alu_vector_checker: ROM-driven self-test sequencer that applies stimulus vectors to a DUT and scores masked responses
module alu_vector_checker #(
  parameter int STIM_W   = 68,
  parameter int RESP_W   = 34,
  parameter int NUM_TEST = 4,
  parameter int ADDR_W   = 8,
  parameter int DUT_LAT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [STIM_W-1:0] stim_rdata,
  input  logic [RESP_W-1:0] ans_rdata,
  output logic [STIM_W-1:0] dut_stim,
  input  logic [RESP_W-1:0] dut_resp,
  input  logic [RESP_W-1:0] resp_mask,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_cnt,
  output logic [ADDR_W:0]   fail_cnt,
  output logic              any_fail,
  output logic [ADDR_W-1:0] first_fail
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_TEST - 1);
  localparam logic [3:0]        WAIT_LOAD = 4'(DUT_LAT > 0 ? DUT_LAT - 1 : 0);
  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_vec_addr;
  logic [STIM_W-1:0]   r_dut_stim;
  logic [RESP_W-1:0]   r_exp;
  logic [3:0]          r_wait_cnt;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_pass_cnt;
  logic [ADDR_W:0]     r_fail_cnt;
  logic                r_any_fail;
  logic [ADDR_W-1:0]   r_first_fail;
  logic                w_mismatch;
  logic [ADDR_W-1:0]   w_idx_next;
  assign w_mismatch = |((dut_resp ^ r_exp) & resp_mask);
  assign w_idx_next = r_idx + 1'b1;
  assign vec_addr   = r_vec_addr;
  assign dut_stim   = r_dut_stim;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign any_fail   = r_any_fail;
  assign first_fail = r_first_fail;
  // sequencer: fetch vector, apply it, wait out DUT latency, score the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_vec_addr   <= '0;
      r_dut_stim   <= '0;
      r_exp        <= '0;
      r_wait_cnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_any_fail   <= 1'b0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_idx        <= '0;
          r_vec_addr   <= '0;
          r_pass_cnt   <= '0;
          r_fail_cnt   <= '0;
          r_any_fail   <= 1'b0;
          r_first_fail <= '0;
          r_busy       <= 1'b1;
          r_state      <= S_READ;
        end
        S_READ: r_state <= S_APPLY;
        S_APPLY: begin
          r_dut_stim <= stim_rdata;
          r_exp      <= ans_rdata;
          r_wait_cnt <= WAIT_LOAD;
          r_state    <= DUT_LAT > 0 ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
          if (r_wait_cnt == '0) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
            if (!r_any_fail) begin
              r_any_fail   <= 1'b1;
              r_first_fail <= r_idx;
            end
          end else begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx      <= w_idx_next;
            r_vec_addr <= w_idx_next;
            r_state    <= S_READ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_vector_checker.sv
// tb_alu_vector_checker: directed checks of the vector sequencer with zero, two and one cycle DUT latency settings
module tb_alu_vector_checker;
  localparam int SW = 68;
  localparam int RW = 34;
  localparam int AW = 8;
  localparam logic [SW-1:0] S0 = {4'b0000, 32'hF0F0F0F0, 32'hFF00FF00};
  localparam logic [SW-1:0] S1 = {4'b0001, 32'h000000FF, 32'h0000FF00};
  localparam logic [SW-1:0] S2 = {4'b0010, 32'h7FFFFFFF, 32'h00000001};
  localparam logic [SW-1:0] S3 = {4'b0000, 32'h12345678, 32'h00000000};
  localparam logic [RW-1:0] A0 = {2'b00, 32'hF000F000};
  localparam logic [RW-1:0] A1 = {2'b00, 32'h0000FFFF};
  localparam logic [RW-1:0] A2 = {2'b10, 32'h80000000};
  localparam logic [RW-1:0] A3 = {2'b01, 32'h00000000};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst_n;
  logic [RW-1:0] resp_mask;
  logic [SW-1:0] stim_rom [4];
  logic [RW-1:0] ans_rom  [4];
  logic          start_v  [3];
  logic [AW-1:0] addr_v   [3];
  logic [SW-1:0] srd_v    [3];
  logic [RW-1:0] ard_v    [3];
  logic [SW-1:0] stim_v   [3];
  logic [RW-1:0] resp_v   [3];
  logic          busy_v   [3];
  logic          done_v   [3];
  logic          anyf_v   [3];
  logic [AW:0]   pass_v   [3];
  logic [AW:0]   fail_v   [3];
  logic [AW-1:0] ff_v     [3];
  logic [RW-1:0] p1       [3];
  logic [RW-1:0] p2       [3];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [RW-1:0] alu(input logic [SW-1:0] s);
    logic [31:0] a, b, r;
    logic ov;
    a  = s[67] ? ~s[63:32] : s[63:32];
    b  = s[66] ? ~s[31:0] : s[31:0];
    ov = 1'b0;
    case (s[65:64])
      2'd0: r = a & b;
      2'd1: r = a | b;
      2'd2: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      default: r = {31'd0, $signed(a) < $signed(b)};
    endcase
    return {ov, r == 32'd0, r};
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      srd_v[k] <= stim_rom[addr_v[k][1:0]];
      ard_v[k] <= ans_rom[addr_v[k][1:0]];
      p1[k]    <= rst_n ? alu(stim_v[k]) : '0;
      p2[k]    <= rst_n ? p1[k] : '0;
    end
  end

  always_comb begin
    resp_v[0] = alu(stim_v[0]);
    resp_v[1] = p2[1];
    resp_v[2] = p2[2];
  end

  alu_vector_checker #(.DUT_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .vec_addr(addr_v[0]),
    .stim_rdata(srd_v[0]), .ans_rdata(ard_v[0]), .dut_stim(stim_v[0]), .dut_resp(resp_v[0]),
    .resp_mask(resp_mask), .busy(busy_v[0]), .done(done_v[0]), .pass_cnt(pass_v[0]),
    .fail_cnt(fail_v[0]), .any_fail(anyf_v[0]), .first_fail(ff_v[0]));
  alu_vector_checker #(.DUT_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .vec_addr(addr_v[1]),
    .stim_rdata(srd_v[1]), .ans_rdata(ard_v[1]), .dut_stim(stim_v[1]), .dut_resp(resp_v[1]),
    .resp_mask(resp_mask), .busy(busy_v[1]), .done(done_v[1]), .pass_cnt(pass_v[1]),
    .fail_cnt(fail_v[1]), .any_fail(anyf_v[1]), .first_fail(ff_v[1]));
  alu_vector_checker #(.DUT_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .vec_addr(addr_v[2]),
    .stim_rdata(srd_v[2]), .ans_rdata(ard_v[2]), .dut_stim(stim_v[2]), .dut_resp(resp_v[2]),
    .resp_mask(resp_mask), .busy(busy_v[2]), .done(done_v[2]), .pass_cnt(pass_v[2]),
    .fail_cnt(fail_v[2]), .any_fail(anyf_v[2]), .first_fail(ff_v[2]));

  task automatic load_roms();
    stim_rom[0] = S0; stim_rom[1] = S1; stim_rom[2] = S2; stim_rom[3] = S3;
    ans_rom[0]  = A0; ans_rom[1]  = A1; ans_rom[2]  = A2; ans_rom[3]  = A3;
    resp_mask   = '1;
  endtask

  task automatic start_run(input int k);
    @(negedge clk) start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk) start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int c0, output int cyc, output int busy_bad);
    cyc = c0;
    busy_bad = 0;
    while (done_v[k] !== 1'b1 && cyc < 200) begin
      if (busy_v[k] !== 1'b1) busy_bad++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    load_roms();
    repeat (3) @(negedge clk);
    n_checks++; if (addr_v[0] !== '0) begin n_fail++; $display("FAIL reset_vec_addr got %0h want 0", addr_v[0]); end
    n_checks++; if (stim_v[0] !== '0) begin n_fail++; $display("FAIL reset_dut_stim got %0h want 0", stim_v[0]); end
    n_checks++; if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy_v[0], done_v[0]); end
    n_checks++; if (pass_v[0] !== '0 || fail_v[0] !== '0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", pass_v[0], fail_v[0]); end
    n_checks++; if (anyf_v[0] !== 1'b0 || ff_v[0] !== '0) begin n_fail++; $display("FAIL reset_any_first got %b/%0d want 0/0", anyf_v[0], ff_v[0]); end
    rst_n = 1'b1;
  endtask

  task automatic test_all_pass();
    int cyc, bb;
    start_run(0);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL all_pass_done_cycle got %0d want 13", cyc); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL all_pass_busy_low_cycles got %0d want 0", bb); end
    n_checks++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL all_pass_busy_in_done got %b want 0", busy_v[0]); end
    n_checks++; if (pass_v[0] !== 9'd4 || fail_v[0] !== 9'd0) begin n_fail++; $display("FAIL all_pass_counts got %0d/%0d want 4/0", pass_v[0], fail_v[0]); end
    n_checks++; if (anyf_v[0] !== 1'b0 || ff_v[0] !== 8'd0) begin n_fail++; $display("FAIL all_pass_any_first got %b/%0d want 0/0", anyf_v[0], ff_v[0]); end
    @(negedge clk);
    n_checks++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL all_pass_done_width got %b want 0", done_v[0]); end
    n_checks++; if (pass_v[0] !== 9'd4 || stim_v[0] !== S3) begin n_fail++; $display("FAIL all_pass_hold got %0d/%0h want 4/%0h", pass_v[0], stim_v[0], S3); end
  endtask

  task automatic test_corrupt();
    int cyc, bb;
    ans_rom[1] = A1 ^ 34'd1;
    ans_rom[3] = A3 ^ 34'd1;
    start_run(0);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (pass_v[0] !== 9'd2 || fail_v[0] !== 9'd2) begin n_fail++; $display("FAIL corrupt_counts got %0d/%0d want 2/2", pass_v[0], fail_v[0]); end
    n_checks++; if (anyf_v[0] !== 1'b1 || ff_v[0] !== 8'd1) begin n_fail++; $display("FAIL corrupt_any_first got %b/%0d want 1/1", anyf_v[0], ff_v[0]); end
    load_roms();
  endtask

  task automatic test_mask();
    int cyc, bb;
    ans_rom[2] = {2'b00, 32'h80000000};
    resp_mask  = 34'h1_FFFF_FFFF;
    start_run(0);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (pass_v[0] !== 9'd4 || fail_v[0] !== 9'd0) begin n_fail++; $display("FAIL mask_ovf_counts got %0d/%0d want 4/0", pass_v[0], fail_v[0]); end
    resp_mask = '1;
    start_run(0);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (fail_v[0] !== 9'd1 || ff_v[0] !== 8'd2) begin n_fail++; $display("FAIL mask_full_counts got %0d/%0d want 1/2", fail_v[0], ff_v[0]); end
    for (int i = 0; i < 4; i++) ans_rom[i] = ~ans_rom[i];
    resp_mask = '0;
    start_run(0);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (pass_v[0] !== 9'd4 || anyf_v[0] !== 1'b0) begin n_fail++; $display("FAIL mask_zero got %0d/%b want 4/0", pass_v[0], anyf_v[0]); end
    load_roms();
  endtask

  task automatic test_latency();
    int cyc, bb;
    start_run(1);
    wait_done(1, 1, cyc, bb);
    n_checks++; if (cyc !== 21) begin n_fail++; $display("FAIL lat2_done_cycle got %0d want 21", cyc); end
    n_checks++; if (pass_v[1] !== 9'd4 || fail_v[1] !== 9'd0 || bb !== 0) begin n_fail++; $display("FAIL lat2_counts got %0d/%0d busy_bad %0d want 4/0/0", pass_v[1], fail_v[1], bb); end
    start_run(2);
    wait_done(2, 1, cyc, bb);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL lat1_done_cycle got %0d want 17", cyc); end
    n_checks++; if (fail_v[2] === 9'd0 || anyf_v[2] !== 1'b1) begin n_fail++; $display("FAIL lat1_mismatch got %0d/%b want nonzero/1", fail_v[2], anyf_v[2]); end
    n_checks++; if (pass_v[2] + fail_v[2] !== 9'd4) begin n_fail++; $display("FAIL lat1_total got %0d want 4", pass_v[2] + fail_v[2]); end
  endtask

  task automatic test_start_ignored();
    int cyc, bb;
    start_run(0);
    repeat (4) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 6, cyc, bb);
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL ignored_start_done_cycle got %0d want 13", cyc); end
    n_checks++; if (pass_v[0] !== 9'd4 || fail_v[0] !== 9'd0 || bb !== 0) begin n_fail++; $display("FAIL ignored_start_counts got %0d/%0d busy_bad %0d want 4/0/0", pass_v[0], fail_v[0], bb); end
  endtask

  task automatic test_reset_mid();
    int cyc, bb;
    int saw_done;
    start_run(0);
    repeat (6) @(negedge clk);
    n_checks++; if (pass_v[0] !== 9'd2) begin n_fail++; $display("FAIL reset_mid_pre_count got %0d want 2", pass_v[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy_done got %b%b want 00", busy_v[0], done_v[0]); end
    n_checks++; if (pass_v[0] !== '0 || fail_v[0] !== '0 || addr_v[0] !== '0) begin n_fail++; $display("FAIL reset_mid_clear got %0d/%0d/%0d want 0/0/0", pass_v[0], fail_v[0], addr_v[0]); end
    saw_done = 0;
    repeat (20) begin @(negedge clk); if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) saw_done++; end
    n_checks++; if (saw_done !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d want 0", saw_done); end
    start_run(0);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (pass_v[0] !== 9'd4 || cyc !== 13) begin n_fail++; $display("FAIL reset_mid_rerun got %0d cyc %0d want 4 cyc 13", pass_v[0], cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc, bb;
    @(negedge clk) start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, 1, cyc, bb);
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL b2b_first_done got %0d want 13", cyc); end
    @(negedge clk);
    n_checks++; if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap got %b%b want 00", busy_v[0], done_v[0]); end
    @(negedge clk);
    wait_done(0, 15, cyc, bb);
    start_v[0] = 1'b0;
    n_checks++; if (cyc !== 27 || bb !== 0) begin n_fail++; $display("FAIL b2b_second_done got %0d busy_bad %0d want 27/0", cyc, bb); end
    n_checks++; if (pass_v[0] !== 9'd4 || fail_v[0] !== 9'd0) begin n_fail++; $display("FAIL b2b_counts got %0d/%0d want 4/0", pass_v[0], fail_v[0]); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_stopped got %b want 0", busy_v[0]); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_corrupt();
    test_mask();
    test_latency();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end
endmodule
